// File: rtl/idecode_pipe.sv
// Minisys decode stage: register file with write-back bypass, immediate extend,
// destination select, busy scoreboard and a registered valid/ready output slot.
// Optional squash port enabled by defining IDECODE_FLUSH_EN.
module idecode_pipe #(
  parameter int DATA_W         = 32,
  parameter int REG_NUM        = 32,
  parameter int ADDR_W         = 5,
  parameter int RESET_INIT_IDX = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] opcplus4,
  input  logic              jal,
  input  logic              regwrite,
  input  logic              regdst,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
`ifdef IDECODE_FLUSH_EN
  input  logic              flush,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic [DATA_W-1:0] sign_extend,
  output logic [ADDR_W-1:0] dest_addr,
  output logic              dest_we,
  output logic [DATA_W-1:0] link_data
);

  logic [DATA_W-1:0] regs [REG_NUM];
  logic [REG_NUM-1:0] busy;

  logic [5:0]        op;
  logic [15:0]       imm;
  logic [ADDR_W-1:0] rs_idx, rt_idx, rd_idx, dest_c;
  logic              dwe_c;
  logic [DATA_W-1:0] rd1_c, rd2_c, imm_c;
  logic              rdy_rs, rdy_rt, rdy_dest, stall, accept, flush_c;

  assign op     = instruction[31:26];
  assign imm    = instruction[15:0];
  assign rs_idx = ADDR_W'(instruction[25:21]);
  assign rt_idx = ADDR_W'(instruction[20:16]);
  assign rd_idx = ADDR_W'(instruction[15:11]);

  assign dest_c = jal ? ADDR_W'(31) : (regdst ? rd_idx : rt_idx);
  assign dwe_c  = (regwrite | jal) & (dest_c != '0);

  // Same-cycle write-back wins over the stored value; register 0 is hardwired.
  assign rd1_c = (rs_idx == '0) ? '0 :
                 (wb_valid && wb_addr == rs_idx) ? wb_data : regs[rs_idx];
  assign rd2_c = (rt_idx == '0) ? '0 :
                 (wb_valid && wb_addr == rt_idx) ? wb_data : regs[rt_idx];

  assign imm_c = (op == 6'h0C || op == 6'h0D || op == 6'h0E) ?
                 {{(DATA_W-16){1'b0}}, imm} : {{(DATA_W-16){imm[15]}}, imm};

  assign rdy_rs   = !busy[rs_idx] | (wb_valid & (wb_addr == rs_idx));
  assign rdy_rt   = !busy[rt_idx] | (wb_valid & (wb_addr == rt_idx));
  assign rdy_dest = !busy[dest_c] | (wb_valid & (wb_addr == dest_c));
  assign stall    = in_valid & (!rdy_rs | !rdy_rt | (dwe_c & !rdy_dest));

`ifdef IDECODE_FLUSH_EN
  assign flush_c = flush;
`else
  assign flush_c = 1'b0;
`endif

  assign in_ready = !stall & (!out_valid | out_ready) & !flush_c;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_NUM; i++)
        regs[i] <= (RESET_INIT_IDX != 0) ? DATA_W'(i) : '0;
    end else if (wb_valid && wb_addr != '0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Later assignments take priority: a new writer's set beats a same-index clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (wb_valid)
        busy[wb_addr] <= 1'b0;
      if (flush_c && out_valid && dest_we)
        busy[dest_addr] <= 1'b0;
      if (accept && dwe_c)
        busy[dest_c] <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      read_data_1 <= '0;
      read_data_2 <= '0;
      sign_extend <= '0;
      dest_addr   <= '0;
      dest_we     <= 1'b0;
      link_data   <= '0;
    end else if (flush_c) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      read_data_1 <= rd1_c;
      read_data_2 <= rd2_c;
      sign_extend <= imm_c;
      dest_addr   <= dest_c;
      dest_we     <= dwe_c;
      link_data   <= opcplus4;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_idecode_pipe.sv
// Bench for idecode_pipe: directed scenarios followed by random traffic,
// all checked against a reference model built on an outstanding-writer list.
module tb_idecode_pipe;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, jal = 1'b0, regwrite = 1'b0, regdst = 1'b0;
  logic        wb_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic [31:0] instruction = '0, opcplus4 = '0, wb_data = '0;
  logic [4:0]  wb_addr = '0;
  logic        in_ready, out_valid, dest_we;
  logic [31:0] read_data_1, read_data_2, sign_extend, link_data;
  logic [4:0]  dest_addr;

  idecode_pipe dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .opcplus4(opcplus4), .jal(jal),
    .regwrite(regwrite), .regdst(regdst), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .wb_data(wb_data),
`ifdef IDECODE_FLUSH_EN
    .flush(flush),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .read_data_1(read_data_1), .read_data_2(read_data_2),
    .sign_extend(sign_extend), .dest_addr(dest_addr), .dest_we(dest_we),
    .link_data(link_data)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  logic last_in_ready;

  // Reference model: register contents, list of registers with a write outstanding, slot contents.
  logic [31:0] m_regs [32];
  int          pend [$];
  bit          s_valid, s_dwe;
  logic [31:0] s_rd1, s_rd2, s_imm, s_link;
  logic [4:0]  s_dest;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'(i);
    pend.delete();
    s_valid = 0; s_dwe = 0; s_rd1 = 0; s_rd2 = 0; s_imm = 0; s_link = 0; s_dest = 0;
  endtask

  function automatic bit outstanding(int r);
    foreach (pend[i]) if (pend[i] == r) return 1;
    return 0;
  endfunction

  function automatic bit usable(int r);
    return r == 0 || !outstanding(r) || (wb_valid && int'(wb_addr) == r);
  endfunction

  function automatic logic [31:0] mread(int r);
    if (r == 0) return 32'h0;
    if (wb_valid && int'(wb_addr) == r) return wb_data;
    return m_regs[r];
  endfunction

  task automatic check_slot();
    chk("out_valid", out_valid, s_valid);
    chk("read_data_1", read_data_1, s_rd1);
    chk("read_data_2", read_data_2, s_rd2);
    chk("sign_extend", sign_extend, s_imm);
    chk("dest_addr", dest_addr, s_dest);
    chk("dest_we", dest_we, s_dwe);
    chk("link_data", link_data, s_link);
  endtask

  // One clock: inputs already driven at the falling edge.
  task automatic step();
    int op, rs, rt, rd, dest;
    bit dwe, stall, exp_rdy, acc;
    logic [31:0] e_rd1, e_rd2, e_imm;
    op = int'(instruction[31:26]); rs = int'(instruction[25:21]);
    rt = int'(instruction[20:16]); rd = int'(instruction[15:11]);
    dest  = jal ? 31 : (regdst ? rd : rt);
    dwe   = (regwrite || jal) && dest != 0;
    stall = in_valid && (!usable(rs) || !usable(rt) || (dwe && !usable(dest)));
    exp_rdy = !stall && (!s_valid || out_ready) && !flush;
    acc   = in_valid && exp_rdy;
    e_rd1 = mread(rs); e_rd2 = mread(rt);
    if (op == 12 || op == 13 || op == 14) e_imm = {16'h0, instruction[15:0]};
    else e_imm = {{16{instruction[15]}}, instruction[15:0]};
    #1;
    chk("in_ready", in_ready, exp_rdy);
    last_in_ready = in_ready;
    @(posedge clock);
    if (wb_valid && wb_addr != 0) m_regs[wb_addr] = wb_data;
    if (wb_valid)
      for (int i = pend.size() - 1; i >= 0; i--) if (pend[i] == int'(wb_addr)) pend.delete(i);
    if (flush && s_valid && s_dwe)
      for (int i = pend.size() - 1; i >= 0; i--) if (pend[i] == int'(s_dest)) pend.delete(i);
    if (acc && dwe) pend.push_back(dest);
    if (flush) s_valid = 0;
    else if (acc) begin
      s_valid = 1; s_rd1 = e_rd1; s_rd2 = e_rd2; s_imm = e_imm;
      s_dest = 5'(dest); s_dwe = dwe; s_link = opcplus4;
    end else if (out_ready) s_valid = 0;
    #1;
    check_slot();
    @(negedge clock);
  endtask

  task automatic set_in(input logic v, input logic [31:0] ins, input logic rdst,
                        input logic rw, input logic j, input logic [31:0] pc4);
    in_valid = v; instruction = ins; regdst = rdst; regwrite = rw; jal = j; opcplus4 = pc4;
  endtask

  initial begin
    logic [31:0] held_imm, held_rd1;
    int op_tab [7] = '{0, 9, 12, 13, 14, 35, 3};
    model_reset();
    #12;
    check_slot();
    chk("reset_in_ready", in_ready, 1'b1);
    @(negedge clock);
    reset = 1'b0;

    // addu $3,$5,$7
    out_ready = 1;
    set_in(1, 32'h00A71821, 1, 1, 0, 32'h0);
    step();
    chk("t1_rd1", read_data_1, 32'd5);
    chk("t1_rd2", read_data_2, 32'd7);
    chk("t1_dest", dest_addr, 5'd3);
    chk("t1_dwe", dest_we, 1'b1);

    // consumer of $3 stalls until write-back, which is bypassed
    set_in(1, 32'h00602021, 1, 1, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_stall", last_in_ready, 1'b0);
    end
    wb_valid = 1; wb_addr = 5'd3; wb_data = 32'h12345678;
    step();
    chk("t2_accept", last_in_ready, 1'b1);
    chk("t2_bypass", read_data_1, 32'h12345678);
    wb_valid = 0;

    // immediate extension
    set_in(1, {6'h09, 5'd1, 5'd2, 16'hFFF0}, 0, 0, 0, 32'h0);
    step();
    chk("t3_addiu", sign_extend, 32'hFFFFFFF0);
    set_in(1, {6'h0D, 5'd1, 5'd2, 16'hFFF0}, 0, 0, 0, 32'h0);
    step();
    chk("t3_ori", sign_extend, 32'h0000FFF0);

    // jal and register 0
    set_in(1, {6'h03, 26'h40}, 0, 1, 1, 32'h104);
    step();
    chk("t4_jal_dest", dest_addr, 5'd31);
    chk("t4_jal_we", dest_we, 1'b1);
    chk("t4_link", link_data, 32'h104);
    set_in(1, 32'h00000021, 1, 1, 0, 32'h0);
    wb_valid = 1; wb_addr = 5'd0; wb_data = 32'hDEAD;
    step();
    wb_valid = 0;
    step();
    chk("t4_r0", read_data_1, 32'h0);
    chk("t4_r0_we", dest_we, 1'b0);

    // backpressure
    set_in(1, {6'h0D, 5'd5, 5'd6, 16'h1234}, 0, 0, 0, 32'h0);
    step();
    held_imm = sign_extend; held_rd1 = read_data_1;
    out_ready = 0;
    set_in(1, {6'h0D, 5'd1, 5'd2, 16'h0055}, 0, 0, 0, 32'h0);
    step();
    chk("t5_blocked", last_in_ready, 1'b0);
    chk("t5_hold_imm", sign_extend, 32'h1234);
    chk("t5_hold_rd1", read_data_1, 32'd5);
    out_ready = 1;
    step();
    chk("t5_release", last_in_ready, 1'b1);
    chk("t5_new_imm", sign_extend, 32'h55);

`ifdef IDECODE_FLUSH_EN
    set_in(1, 32'h00224821, 1, 1, 0, 32'h0);
    step();
    out_ready = 0; flush = 1; in_valid = 0;
    step();
    chk("t6_flushed", out_valid, 1'b0);
    flush = 0; out_ready = 1;
    set_in(1, 32'h01205021, 1, 1, 0, 32'h0);
    step();
    chk("t6_no_stall", last_in_ready, 1'b1);
`endif

    // random traffic with one asynchronous reset in the middle
    for (int i = 0; i < 400; i++) begin
      int op, rs, rt, rd;
      op = op_tab[$urandom_range(0, 6)];
      rs = ($urandom_range(0, 9) == 0) ? 31 : $urandom_range(0, 7);
      rt = $urandom_range(0, 7);
      rd = $urandom_range(0, 7);
      set_in($urandom_range(0, 3) != 0,
             {6'(op), 5'(rs), 5'(rt), 5'(rd), 5'($urandom_range(0, 31)), 6'h21} ^
             {16'h0, 16'($urandom)} & 32'h0000FFFF | {6'(op), 5'(rs), 5'(rt), 16'h0},
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'(op == 3), $urandom);
      instruction = {6'(op), 5'(rs), 5'(rt), 5'(rd), 11'($urandom)};
      wb_valid = ($urandom_range(0, 9) < 4);
      if (pend.size() > 0 && $urandom_range(0, 1) == 1)
        wb_addr = 5'(pend[$urandom_range(0, pend.size() - 1)]);
      else
        wb_addr = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
`ifdef IDECODE_FLUSH_EN
      flush = ($urandom_range(0, 9) == 0);
`endif
      if (i == 200) begin
        reset = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_we", dest_we, 1'b0);
        chk("midrst_rd1", read_data_1, 32'h0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
      end else begin
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
